// File: rtl/clk_step_ctrl_pkg.sv
// Shared definitions for the run/stop/single-step clock-enable controller:
// state codes, the first manual rate code and the status encoding.
package clk_step_ctrl_pkg;

   typedef enum logic [1:0] {
      CSC_STOP = 2'd0,
      CSC_RUN  = 2'd1,
      CSC_STEP = 2'd2,
      CSC_HALT = 2'd3
   } csc_state_e;

   localparam logic [3:0] RATE_MANUAL = 4'd12;
   localparam int unsigned CE_W = 32;

   // Status word is {running, step_pending, halted}
   function automatic logic [2:0] clk_stat_of(input csc_state_e s);
      return {s == CSC_RUN, s == CSC_STEP, s == CSC_HALT};
   endfunction

endpackage

// File: rtl/clk_step_ctrl_if.sv
// Board-side bundle of the clock controller: rate switches, buttons, halt
// request in; clock enable, run flag, status and pulse counter out.
interface clk_step_ctrl_if;
   import clk_step_ctrl_pkg::*;

   logic [3:0]      rate_sel;
   logic            btn_run;
   logic            btn_step;
   logic            halt_req;
   logic            cpu_ce;
   logic            running;
   logic [2:0]      clk_stat;
   logic [CE_W-1:0] ce_count;

   modport master (
      input  rate_sel, btn_run, btn_step, halt_req,
      output cpu_ce, running, clk_stat, ce_count
   );

   modport slave (
      output rate_sel, btn_run, btn_step, halt_req,
      input  cpu_ce, running, clk_stat, ce_count
   );

endinterface

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-count debounce and a
// one-cycle pulse on each rising edge of the debounced level.
module clk_step_ctrl_btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // Any sample that agrees with the current level restarts the count
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/stop/single-step controller: issues a one-cycle CPU clock enable at a
// switch-selected rate, with debounced buttons and a CPU halt request.
module clk_step_ctrl
   import clk_step_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned CNT_W        = 32
) (
   input logic           clk,
   input logic           reset,
   clk_step_ctrl_if.master bus
);

   function automatic logic [CNT_W-1:0] sat_div(input int unsigned q);
      return (q == 0) ? CNT_W'(1) : CNT_W'(q);
   endfunction

   logic             run_press, step_press;
   logic [3:0]       rate_q;
   logic [CNT_W-1:0] div_val;
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             manual, rate_chg, tick;
   csc_state_e       state_q, state_d;
   logic             cpu_ce_q, cpu_ce_d;
   logic             running_q;
   logic [2:0]       clk_stat_q;
   logic [CE_W-1:0]  ce_count_q;

   clk_step_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_run (
      .clk(clk), .reset(reset), .btn_i(bus.btn_run), .press_o(run_press)
   );

   clk_step_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_step (
      .clk(clk), .reset(reset), .btn_i(bus.btn_step), .press_o(step_press)
   );

   always_comb begin
      div_val = CNT_W'(1);
      case (bus.rate_sel)
         4'd0:    div_val = sat_div(CLK_HZ / 32'd1);
         4'd1:    div_val = sat_div(CLK_HZ / 32'd10);
         4'd2:    div_val = sat_div(CLK_HZ / 32'd100);
         4'd3:    div_val = sat_div(CLK_HZ / 32'd1_000);
         4'd4:    div_val = sat_div(CLK_HZ / 32'd10_000);
         4'd5:    div_val = sat_div(CLK_HZ / 32'd100_000);
         4'd6:    div_val = sat_div(CLK_HZ / 32'd1_000_000);
         4'd7:    div_val = sat_div(CLK_HZ / 32'd10_000_000);
         4'd8:    div_val = sat_div(CLK_HZ / 32'd20_000_000);
         4'd9:    div_val = sat_div(CLK_HZ / 32'd25_000_000);
         4'd10:   div_val = sat_div(CLK_HZ / 32'd50_000_000);
         4'd11:   div_val = sat_div(CLK_HZ / CLK_HZ);
         default: div_val = CNT_W'(1);
      endcase
   end

   // A rate change restarts the divider; the cycle of the change never ticks
   assign manual    = (bus.rate_sel >= RATE_MANUAL);
   assign rate_chg  = (bus.rate_sel != rate_q);
   assign tick      = !manual && !rate_chg && (div_cnt_q == div_val - CNT_W'(1));
   assign div_cnt_d = (manual || rate_chg || tick) ? '0 : div_cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         rate_q    <= bus.rate_sel;
         div_cnt_q <= '0;
      end else begin
         rate_q    <= bus.rate_sel;
         div_cnt_q <= div_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= CSC_STOP;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CSC_STOP: begin
            if (run_press && !manual) state_d = CSC_RUN;
            else if (step_press)      state_d = CSC_STEP;
         end
         CSC_RUN: begin
            if (bus.halt_req)   state_d = CSC_HALT;
            else if (run_press) state_d = CSC_STOP;
            else if (manual)    state_d = CSC_STOP;
         end
         CSC_STEP: state_d = CSC_STOP;
         CSC_HALT: begin
            if (run_press && !bus.halt_req) state_d = CSC_RUN;
            else if (step_press)            state_d = CSC_STEP;
         end
         default: state_d = CSC_STOP;
      endcase
   end

   // A step always fires; a run tick is dropped while a halt is requested
   always_comb begin
      cpu_ce_d = (state_q == CSC_STEP) ||
                 ((state_q == CSC_RUN) && tick && !bus.halt_req);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_ce_q   <= 1'b0;
         running_q  <= 1'b0;
         clk_stat_q <= 3'b000;
         ce_count_q <= '0;
      end else begin
         cpu_ce_q   <= cpu_ce_d;
         running_q  <= (state_d == CSC_RUN);
         clk_stat_q <= clk_stat_of(state_d);
         ce_count_q <= ce_count_q + CE_W'(cpu_ce_q);
      end
   end

   assign bus.cpu_ce   = cpu_ce_q;
   assign bus.running  = running_q;
   assign bus.clk_stat = clk_stat_q;
   assign bus.ce_count = ce_count_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: directed scenarios plus a randomized stretch, all
// compared every cycle against a behavioural model of the controller rules.
module tb_clk_step_ctrl;

   localparam longint CLK = 1000;
   localparam int     DB  = 4;
   localparam int     HL  = DB + 3;

   logic clk;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   n_ce_seen = 0;
   int   n_stat010 = 0;

   clk_step_ctrl_if bus ();

   clk_step_ctrl #(.CLK_HZ(1000), .DEBOUNCE_CYC(DB), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Reference model: 0=STOP 1=RUN 2=STEP 3=HALT
   int          m_st, m_age, m_prev_rate;
   bit          m_ce, m_rlvl, m_slvl, m_rp, m_sp, m_valid;
   int unsigned m_cnt;
   bit          h_run[$], h_step[$];

   function automatic int div_of(input int r);
      longint hz;
      case (r)
         0: hz = 1;        1: hz = 10;       2: hz = 100;
         3: hz = 1000;     4: hz = 10000;    5: hz = 100000;
         6: hz = 1000000;  7: hz = 10000000; 8: hz = 20000000;
         9: hz = 25000000; 10: hz = 50000000; 11: hz = CLK;
         default: return 1;
      endcase
      if (CLK / hz < 1) return 1;
      return int'(CLK / hz);
   endfunction

   // Level flips once the last DB synchronized samples all disagree with it
   function automatic bit settled(input bit h[$], input bit lvl);
      int n = h.size();
      for (int j = 0; j < DB; j++) if (h[n-3-j] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      int r;
      bit hr, tck, nce;
      int nst, d;
      r  = int'(bus.rate_sel);
      hr = bus.halt_req;
      if (reset) begin
         m_st = 0; m_ce = 0; m_cnt = 0; m_age = 0; m_prev_rate = r;
         m_rlvl = 0; m_slvl = 0; m_rp = 0; m_sp = 0; m_valid = 1;
         h_run = {}; h_step = {};
         for (int i = 0; i < HL; i++) begin h_run.push_back(1'b0); h_step.push_back(1'b0); end
         return;
      end
      d   = div_of(r);
      tck = (r < 12) && (r == m_prev_rate) && ((m_age % d) == d - 1);
      if (r != m_prev_rate) begin m_prev_rate = r; m_age = 0; end
      else m_age++;
      m_cnt += m_ce;
      nst = m_st; nce = 1'b0;
      case (m_st)
         0: if (m_rp && r < 12) nst = 1; else if (m_sp) nst = 2;
         1: begin
            nce = tck && !hr;
            if (hr) nst = 3; else if (m_rp) nst = 0; else if (r >= 12) nst = 0;
         end
         2: begin nce = 1'b1; nst = 0; end
         default: if (m_rp && !hr) nst = 1; else if (m_sp) nst = 2;
      endcase
      m_ce = nce; m_st = nst;
      h_run.push_back(bus.btn_run);   void'(h_run.pop_front());
      h_step.push_back(bus.btn_step); void'(h_step.pop_front());
      m_rp = 1'b0; m_sp = 1'b0;
      if (settled(h_run, m_rlvl))  begin m_rlvl = !m_rlvl; m_rp = m_rlvl; end
      if (settled(h_step, m_slvl)) begin m_slvl = !m_slvl; m_sp = m_slvl; end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (bus.cpu_ce === 1'b1) n_ce_seen++;
      if (bus.clk_stat === 3'b010) n_stat010++;
      if (m_valid) begin
         check("m_cpu_ce", bus.cpu_ce, m_ce);
         check("m_running", bus.running, m_st == 1);
         check("m_clk_stat", bus.clk_stat, {m_st == 1, m_st == 2, m_st == 3});
         check("m_ce_count", bus.ce_count, m_cnt);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) tick_cycle();
   endtask

   task automatic set_btn(input bit which, input bit v);
      if (which) bus.btn_step = v; else bus.btn_run = v;
   endtask

   // Short bounce, then a steady press long enough to register, then release
   task automatic press(input bit which);
      int nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
         set_btn(which, 1'b1); cyc($urandom_range(1, 2));
         set_btn(which, 1'b0); cyc(1);
      end
      set_btn(which, 1'b1); cyc(DB + 2 + $urandom_range(1, 3));
      set_btn(which, 1'b0); cyc(DB + 3);
   endtask

   task automatic cycles_to_ce(input int budget, output int n);
      n = 0;
      do begin tick_cycle(); n++; end while (bus.cpu_ce !== 1'b1 && n < budget);
   endtask

   initial begin
      int start, e0, s0, gap;
      int pick[6] = '{1, 2, 3, 11, 12, 5};
      m_valid = 0;
      reset = 1'b1;
      bus.rate_sel = 4'd3; bus.btn_run = 1'b0; bus.btn_step = 1'b0; bus.halt_req = 1'b0;

      // 1: reset
      cyc(3);
      check("rst_cpu_ce", bus.cpu_ce, 0);
      check("rst_running", bus.running, 0);
      check("rst_clk_stat", bus.clk_stat, 0);
      check("rst_ce_count", bus.ce_count, 0);
      reset = 1'b0;
      cyc(2);

      // 2: run at DIV=1, then stop
      press(1'b0);
      check("t2_running", bus.running, 1);
      start = int'(bus.ce_count);
      cyc(50);
      check("t2_cnt50", bus.ce_count - 32'(start), 50);
      press(1'b0);
      check("t2_stopped", bus.running, 0);
      e0 = n_ce_seen;
      cyc(20);
      check("t2_no_pulses", n_ce_seen - e0, 0);

      // 3: DIV=1000 period, then switch to DIV=100 mid-count
      bus.rate_sel = 4'd0;
      cyc(2);
      press(1'b0);
      cycles_to_ce(1100, gap);
      cycles_to_ce(1100, gap);
      check("t3_period1000", gap, 1000);
      cyc(300);
      bus.rate_sel = 4'd1;
      tick_cycle();
      cycles_to_ce(200, gap);
      check("t3_after_change", gap, 100);
      cycles_to_ce(200, gap);
      check("t3_period100", gap, 100);
      press(1'b0);
      check("t3_stopped", bus.running, 0);

      // 4: manual rate, three single steps, run ignored
      bus.rate_sel = 4'd12;
      cyc(2);
      start = int'(bus.ce_count); e0 = n_ce_seen; s0 = n_stat010;
      for (int k = 0; k < 3; k++) press(1'b1);
      cyc(2);
      check("t4_ce_count", bus.ce_count - 32'(start), 3);
      check("t4_pulses", n_ce_seen - e0, 3);
      check("t4_stat010", n_stat010 - s0, 3);
      press(1'b0);
      check("t4_run_ignored", bus.running, 0);

      // 5: halt from RUN, step through halt, resume from HALT
      bus.rate_sel = 4'd3;
      cyc(2);
      press(1'b0);
      bus.halt_req = 1'b1;
      tick_cycle();
      check("t5_halt_ce", bus.cpu_ce, 0);
      check("t5_halt_stat", bus.clk_stat, 3'b001);
      e0 = n_ce_seen;
      press(1'b1);
      check("t5_step_pulse", n_ce_seen - e0, 1);
      check("t5_step_stop", bus.clk_stat, 3'b000);
      bus.halt_req = 1'b0;
      press(1'b0);
      check("t5_rerun", bus.running, 1);
      bus.halt_req = 1'b1;
      cyc(2);
      bus.halt_req = 1'b0;
      cyc(1);
      check("t5_held", bus.clk_stat, 3'b001);
      press(1'b0);
      check("t5_resume", bus.running, 1);

      // 6: bounce glitches, then reset during RUN
      for (int k = 0; k < 6; k++) begin
         bus.btn_run = 1'b1; cyc($urandom_range(1, 3));
         bus.btn_run = 1'b0; cyc($urandom_range(1, 4));
      end
      cyc(DB + 3);
      check("t6_glitch", bus.running, 1);
      reset = 1'b1;
      tick_cycle();
      check("t6_rst_running", bus.running, 0);
      check("t6_rst_count", bus.ce_count, 0);
      check("t6_rst_ce", bus.cpu_ce, 0);
      cyc(1);
      reset = 1'b0;
      cyc(2);

      // Randomized stretch against the model
      for (int blk = 0; blk < 120; blk++) begin
         if ($urandom_range(0, 7) == 0) bus.rate_sel = 4'(pick[$urandom_range(0, 5)]);
         if ($urandom_range(0, 5) == 0) bus.halt_req = ~bus.halt_req;
         bus.btn_run  = 1'($urandom_range(0, 1));
         bus.btn_step = 1'($urandom_range(0, 3) == 0);
         cyc($urandom_range(1, 12));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
